// File: rtl/dump_seq_ctrl.sv
// dump_seq_ctrl
//   Sequences the receiver-coil dump switch around every RF pulse of a CPMG
//   echo train. After being armed by state_start, each pulse_end strobe runs
//   the sequence settle delay -> dead time -> dump-on window -> dead time.
//   The complementary gate drives always break before make.
//
// Ports
//   clk_sys      system clock
//   rst          asynchronous, active-high reset
//   state_start  one-cycle strobe that arms a train (ignored while busy)
//   abort        level; forces the safe state (highest priority)
//   pulse_end    one-cycle strobe at the end of each RF pulse
//   cfg_delay    settle cycles after pulse_end
//   cfg_guard    dead-time cycles (0 behaves as 1)
//   cfg_width    dump-on cycles (0 skips dead times and dump entirely)
//   cfg_pulses   pulses per train
//   dump_on      dump switch on drive
//   dump_off     dump switch off drive
//   busy         train in progress
//   done         one-cycle strobe at train completion
//   pulse_idx    pulses completed in the current train
//   err_overrun  sticky; pulse_end arrived while busy but not waiting
//
// All outputs are registered.

module dump_seq_ctrl #(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned NUM_W = 12
) (
   input  logic             clk_sys,
   input  logic             rst,
   input  logic             state_start,
   input  logic             abort,
   input  logic             pulse_end,
   input  logic [CNT_W-1:0] cfg_delay,
   input  logic [CNT_W-1:0] cfg_guard,
   input  logic [CNT_W-1:0] cfg_width,
   input  logic [NUM_W-1:0] cfg_pulses,
   output logic             dump_on,
   output logic             dump_off,
   output logic             busy,
   output logic             done,
   output logic [NUM_W-1:0] pulse_idx,
   output logic             err_overrun
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DELAY,
      S_DEAD_A,
      S_DUMP,
      S_DEAD_B
   } state_t;

   state_t           state, next_state;
   logic [CNT_W-1:0] timer, timer_nxt;

   // configuration captured on the accepted start
   logic [CNT_W-1:0] delay_q, guard_q, width_q;
   logic [NUM_W-1:0] pulses_q;

   // next-state side information
   logic             start_ok;
   logic             done_set;
   logic             idx_inc;
   logic             overrun_set;

   logic [CNT_W-1:0] guard_load;
   logic [NUM_W-1:0] idx_plus;
   logic             last_pulse;
   state_t           fin_state;

   // next values of the registered outputs
   logic             dump_on_nxt, dump_off_nxt, busy_nxt, done_nxt, err_nxt;
   logic [NUM_W-1:0] idx_nxt;

   // Timers hold "cycles remaining minus one", so a state lasts load+1 cycles.
   assign guard_load = (guard_q == '0) ? '0 : guard_q - CNT_W'(1);
   assign idx_plus   = pulse_idx + NUM_W'(1);
   assign last_pulse = (idx_plus == pulses_q);
   assign fin_state  = last_pulse ? S_IDLE : S_WAIT;

   // ------------------------------------------------------------------
   // State register, timer and configuration latch
   // ------------------------------------------------------------------
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         timer    <= '0;
         delay_q  <= '0;
         guard_q  <= '0;
         width_q  <= '0;
         pulses_q <= '0;
      end else begin
         state <= next_state;
         timer <= timer_nxt;
         if (start_ok) begin
            delay_q  <= cfg_delay;
            guard_q  <= cfg_guard;
            width_q  <= cfg_width;
            pulses_q <= cfg_pulses;
         end
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      next_state  = state;
      timer_nxt   = (timer != '0) ? timer - CNT_W'(1) : '0;
      start_ok    = 1'b0;
      done_set    = 1'b0;
      idx_inc     = 1'b0;
      overrun_set = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (state_start) begin
               start_ok = 1'b1;
               // an empty train completes immediately without going busy
               if (cfg_pulses == '0) done_set = 1'b1;
               else                  next_state = S_WAIT;
            end
         end

         S_WAIT: begin
            if (pulse_end) begin
               if (delay_q != '0) begin
                  next_state = S_DELAY;
                  timer_nxt  = delay_q - CNT_W'(1);
               end else if (width_q != '0) begin
                  next_state = S_DEAD_A;
                  timer_nxt  = guard_load;
               end else begin
                  idx_inc    = 1'b1;
                  done_set   = last_pulse;
                  next_state = fin_state;
               end
            end
         end

         S_DELAY: begin
            if (timer == '0) begin
               if (width_q != '0) begin
                  next_state = S_DEAD_A;
                  timer_nxt  = guard_load;
               end else begin
                  // zero width: no dead times, no dump, pulse still counted
                  idx_inc    = 1'b1;
                  done_set   = last_pulse;
                  next_state = fin_state;
               end
            end
         end

         S_DEAD_A: begin
            if (timer == '0) begin
               next_state = S_DUMP;
               timer_nxt  = width_q - CNT_W'(1);
            end
         end

         S_DUMP: begin
            if (timer == '0) begin
               next_state = S_DEAD_B;
               timer_nxt  = guard_load;
            end
         end

         S_DEAD_B: begin
            if (timer == '0) begin
               idx_inc    = 1'b1;
               done_set   = last_pulse;
               next_state = fin_state;
            end
         end

         default: next_state = S_IDLE;
      endcase

      if (pulse_end && state != S_IDLE && state != S_WAIT)
         overrun_set = 1'b1;

      if (abort) begin
         next_state = S_IDLE;
         timer_nxt  = '0;
         start_ok   = 1'b0;
         done_set   = 1'b0;
         idx_inc    = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Output logic (next values of the output registers)
   // ------------------------------------------------------------------
   always_comb begin
      // Each gate may only rise while the opposite gate is already low.
      // Normal sequencing always passes a dead-time state; this interlock
      // is what keeps the both-low cycle when abort leaves DUMP directly.
      dump_on_nxt  = (next_state == S_DUMP) && !dump_off;
      dump_off_nxt = (next_state == S_IDLE || next_state == S_WAIT ||
                      next_state == S_DELAY) && !dump_on;
      busy_nxt     = (next_state != S_IDLE);
      done_nxt     = done_set;

      idx_nxt = pulse_idx;
      if (start_ok)     idx_nxt = '0;
      else if (idx_inc) idx_nxt = idx_plus;

      err_nxt = err_overrun;
      if (start_ok)         err_nxt = 1'b0;
      else if (overrun_set) err_nxt = 1'b1;
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         dump_on     <= 1'b0;
         dump_off    <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         pulse_idx   <= '0;
         err_overrun <= 1'b0;
      end else begin
         dump_on     <= dump_on_nxt;
         dump_off    <= dump_off_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;
         pulse_idx   <= idx_nxt;
         err_overrun <= err_nxt;
      end
   end

endmodule

// File: doc/dump_seq_ctrl.md
Name: dump_seq_ctrl

Overview:
- Sequences the receiver-coil dump switch around every RF pulse of a CPMG echo train.
- Armed by state_start from the pulse-sequence master. For each pulse_end strobe from the transmitter it runs: programmable settle delay, dead time, dump-on window, dead time.
- Drives the complementary dump_on/dump_off gate signals with guaranteed break-before-make.
- Sits between the sequence state machine and the dump driver stage.

Parameters:
- CNT_W, 16, width of delay/width/guard timers in clk_sys cycles.
- NUM_W, 12, width of the pulse counter.

Ports:
- clk_sys  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- state_start  in  1  one-cycle strobe that arms a train.
- abort  in  1  level; forces safe state.
- pulse_end  in  1  one-cycle strobe at the end of each RF pulse.
- cfg_delay  in  CNT_W  settle cycles after pulse_end.
- cfg_guard  in  CNT_W  dead-time cycles; 0 is treated as 1.
- cfg_width  in  CNT_W  dump-on cycles.
- cfg_pulses  in  NUM_W  pulses per train.
- dump_on  out  1  dump switch on drive.
- dump_off  out  1  dump switch off drive.
- busy  out  1  train in progress.
- done  out  1  one-cycle strobe at train completion.
- pulse_idx  out  NUM_W  pulses completed in the current train.
- err_overrun  out  1  sticky; a pulse_end arrived outside WAIT.

Behaviour:
- Reset values: dump_on=0, dump_off=1, busy=0, done=0, pulse_idx=0, err_overrun=0, state IDLE.
- All outputs are registered.
- dump_on and dump_off are never 1 in the same cycle.
- States and output encoding:
  - IDLE, WAIT, DELAY: dump_off=1, dump_on=0.
  - DEAD_A, DEAD_B: both 0.
  - DUMP: dump_on=1, dump_off=0.
- Configuration is latched on the accepted state_start and is stable for the whole train.
- IDLE:
  - state_start=1 → latch cfg, clear pulse_idx and err_overrun, busy=1, go to WAIT next cycle.
  - If cfg_pulses=0: no WAIT; done pulses the next cycle, busy stays 0.
- WAIT: pulse_end=1 → DELAY, timer=cfg_delay. If cfg_delay=0, go straight to DEAD_A.
- DELAY: stays exactly cfg_delay cycles → DEAD_A.
- DEAD_A: stays max(cfg_guard,1) cycles → DUMP.
- DUMP: stays cfg_width cycles → DEAD_B.
- DEAD_B: stays max(cfg_guard,1) cycles. On exit, pulse_idx+1. Then:
  - if pulse_idx+1 == cfg_pulses → IDLE, done=1 for one cycle, busy=0 in the same cycle.
  - else → WAIT.
- cfg_width=0: DELAY exits directly to pulse-count logic (no dead times, no dump). pulse_idx still increments.
- Latency: pulse_end at cycle T → dump_on first high at T+1+cfg_delay+max(cfg_guard,1), held for cfg_width cycles.
- pulse_end outside WAIT while busy: ignored, err_overrun set (sticky until the next accepted start). In IDLE it is ignored without error.
- state_start while busy: ignored.
- abort (highest priority, any state): next cycle IDLE with dump_on=0, dump_off=1, busy=0. No done pulse; pulse_idx holds its value.
  - From DUMP this skips DEAD_B. dump_on falls in the same edge, dump_off rises on the next edge, so one both-low cycle is preserved.
- Asynchronous rst mid-train: all outputs return to reset values immediately.
- Timers are down-counters loaded on state entry. No wrap-around: the pulse counter compares for equality and cannot exceed cfg_pulses.

Test Plan:
1. Reset, cfg_delay=5, guard=2, width=10, pulses=3; start; pulse_end at T → dump_off low at T+6, dump_on high T+8..T+17, dump_off high again T+20; after 3 pulses done=1 for one cycle, pulse_idx=3, busy=0.
2. cfg_guard=0, delay=0, width=1, pulses=1; pulse_end at T → dump_on high only at T+2, with one both-low cycle on each side; done after.
3. abort asserted in the 4th DUMP cycle → dump_on=0 next edge, dump_off=1 one cycle later, busy=0, no done, pulse_idx unchanged.
4. Extra pulse_end during DUMP → err_overrun=1 and stays 1; train timing unaffected. Next start clears err_overrun.
5. cfg_pulses=0, start → done at the next cycle, dump_on never asserts. cfg_width=0, pulses=2 → pulse_idx reaches 2, dump_off stays 1 throughout.
6. rst asserted mid-DUMP → dump_on=0, dump_off=1 asynchronously; subsequent state_start while busy is ignored; a check that dump_on&&dump_off is never 1 runs in all tests.
